// File: rtl/hwce_wmem_pkg.sv
// rtl/hwce_wmem_pkg.sv - shared widths, types and address decode for the weight-memory arbiter
package hwce_wmem_pkg;

    localparam int unsigned WMEM_N_REQ   = 4;
    localparam int unsigned WMEM_N_BANKS = 8;
    localparam int unsigned BANK_SEL_W   = $clog2(WMEM_N_BANKS);
    localparam int unsigned REQ_IDX_W    = $clog2(WMEM_N_REQ);

    typedef logic [BANK_SEL_W-1:0] bank_idx_t;

    // Extracts a width-bit field starting at lsb; used for both bank select and word address.
    function automatic logic [31:0] addr_field(input logic [63:0] addr,
                                               input int unsigned lsb,
                                               input int unsigned width);
        logic [63:0] mask;
        mask = (64'd1 << width) - 64'd1;
        return 32'((addr >> lsb) & mask);
    endfunction

endpackage

// File: rtl/hwce_rr_arb.sv
// rtl/hwce_rr_arb.sv - round-robin arbiter with one-hot grant and pointer advance on grant
module hwce_rr_arb #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] gnt_o
);

    localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] idx;
    logic             found;

    // Scan from the pointer upward with wrap; the first requester found wins.
    always_comb begin
        gnt_o = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = PTR_W'((32'(ptr_q) + i) % N);
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                ptr_d      = PTR_W'((32'(idx) + 1) % N);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/hwce_wmem_arbiter.sv
// rtl/hwce_wmem_arbiter.sv - per-bank round-robin sharing of weight-memory banks with read-response routing
module hwce_wmem_arbiter
    import hwce_wmem_pkg::*;
#(
    parameter int unsigned N_REQ           = WMEM_N_REQ,
    parameter int unsigned N_BANKS         = WMEM_N_BANKS,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned BE_WIDTH        = DATA_WIDTH / 8,
    parameter int unsigned LSB_ADDR        = 2,
    parameter int unsigned BANK_ADDR_WIDTH = 12
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [N_REQ-1:0]                   req_i,
    input  logic [N_REQ*ADDR_WIDTH-1:0]        add_i,
    input  logic [N_REQ-1:0]                   wen_i,
    input  logic [N_REQ*DATA_WIDTH-1:0]        wdata_i,
    input  logic [N_REQ*BE_WIDTH-1:0]          be_i,
    output logic [N_REQ-1:0]                   gnt_o,
    output logic [N_REQ-1:0]                   r_valid_o,
    output logic [N_REQ*DATA_WIDTH-1:0]        r_rdata_o,
    output logic [N_BANKS-1:0]                 bank_req_o,
    output logic [N_BANKS*BANK_ADDR_WIDTH-1:0] bank_add_o,
    output logic [N_BANKS-1:0]                 bank_wen_o,
    output logic [N_BANKS*DATA_WIDTH-1:0]      bank_wdata_o,
    output logic [N_BANKS*BE_WIDTH-1:0]        bank_be_o,
    input  logic [N_BANKS*DATA_WIDTH-1:0]      bank_rdata_i
);

    localparam int unsigned SEL_W = $clog2(N_BANKS);

    logic [SEL_W-1:0]           req_bank  [N_REQ];
    logic [BANK_ADDR_WIDTH-1:0] req_word  [N_REQ];
    logic [N_REQ-1:0]           bank_reqs [N_BANKS];
    logic [N_REQ-1:0]           bank_gnts [N_BANKS];
    logic [DATA_WIDTH-1:0]      rdata_arr [N_BANKS];

    logic [N_REQ-1:0] valid_q, rd_q;
    logic [SEL_W-1:0] bank_q [N_REQ];

    always_comb begin
        for (int k = 0; k < N_REQ; k++) begin
            req_bank[k] = SEL_W'(addr_field(64'(add_i[k*ADDR_WIDTH +: ADDR_WIDTH]), LSB_ADDR, SEL_W));
            req_word[k] = BANK_ADDR_WIDTH'(addr_field(64'(add_i[k*ADDR_WIDTH +: ADDR_WIDTH]),
                                                      LSB_ADDR + SEL_W, BANK_ADDR_WIDTH));
        end
        for (int b = 0; b < N_BANKS; b++) begin
            for (int k = 0; k < N_REQ; k++) begin
                bank_reqs[b][k] = req_i[k] && (req_bank[k] == SEL_W'(b));
            end
        end
    end

    for (genvar b = 0; b < N_BANKS; b++) begin : g_bank_arb
        hwce_rr_arb #(.N(N_REQ)) u_arb (
            .clk   (clk),
            .rst   (rst),
            .req_i (bank_reqs[b]),
            .gnt_o (bank_gnts[b])
        );
    end

    // Each bank forwards its single winner's fields; idle banks drive zero.
    always_comb begin
        gnt_o        = '0;
        bank_req_o   = '0;
        bank_add_o   = '0;
        bank_wen_o   = '0;
        bank_wdata_o = '0;
        bank_be_o    = '0;
        for (int b = 0; b < N_BANKS; b++) begin
            bank_req_o[b] = |bank_gnts[b];
            for (int k = 0; k < N_REQ; k++) begin
                if (bank_gnts[b][k]) begin
                    gnt_o[k]                                      = 1'b1;
                    bank_add_o[b*BANK_ADDR_WIDTH +: BANK_ADDR_WIDTH] = req_word[k];
                    bank_wen_o[b]                                 = wen_i[k];
                    bank_wdata_o[b*DATA_WIDTH +: DATA_WIDTH]      = wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
                    bank_be_o[b*BE_WIDTH +: BE_WIDTH]             = be_i[k*BE_WIDTH +: BE_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            rd_q    <= '0;
            for (int k = 0; k < N_REQ; k++) begin
                bank_q[k] <= '0;
            end
        end else begin
            valid_q <= gnt_o;
            for (int k = 0; k < N_REQ; k++) begin
                if (gnt_o[k]) begin
                    rd_q[k]   <= wen_i[k];
                    bank_q[k] <= req_bank[k];
                end
            end
        end
    end

    // Responses are suppressed while rst is high so a pending load is dropped immediately.
    always_comb begin
        r_valid_o = '0;
        r_rdata_o = '0;
        for (int b = 0; b < N_BANKS; b++) begin
            rdata_arr[b] = bank_rdata_i[b*DATA_WIDTH +: DATA_WIDTH];
        end
        for (int k = 0; k < N_REQ; k++) begin
            if (valid_q[k] && !rst) begin
                r_valid_o[k] = 1'b1;
                if (rd_q[k]) begin
                    r_rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = rdata_arr[bank_q[k]];
                end
            end
        end
    end

endmodule

// File: tb/tb_hwce_wmem_arbiter.sv
// tb/tb_hwce_wmem_arbiter.sv - directed self-checking bench for hwce_wmem_arbiter
module tb_hwce_wmem_arbiter;
    import hwce_wmem_pkg::*;

    localparam int NR = 4;
    localparam int NB = 8;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int BAW = 12;

    logic               clk = 1'b0;
    logic               rst;
    logic [NR-1:0]      req_i;
    logic [NR*AW-1:0]   add_i;
    logic [NR-1:0]      wen_i;
    logic [NR*DW-1:0]   wdata_i;
    logic [NR*BW-1:0]   be_i;
    logic [NR-1:0]      gnt_o;
    logic [NR-1:0]      r_valid_o;
    logic [NR*DW-1:0]   r_rdata_o;
    logic [NB-1:0]      bank_req_o;
    logic [NB*BAW-1:0]  bank_add_o;
    logic [NB-1:0]      bank_wen_o;
    logic [NB*DW-1:0]   bank_wdata_o;
    logic [NB*BW-1:0]   bank_be_o;
    logic [NB*DW-1:0]   bank_rdata_i;

    logic [DW-1:0] mem     [NB][16];
    logic [DW-1:0] rdata_q [NB];

    int n_chk  = 0;
    int n_pass = 0;

    hwce_wmem_arbiter u_dut (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req_i),
        .add_i        (add_i),
        .wen_i        (wen_i),
        .wdata_i      (wdata_i),
        .be_i         (be_i),
        .gnt_o        (gnt_o),
        .r_valid_o    (r_valid_o),
        .r_rdata_o    (r_rdata_o),
        .bank_req_o   (bank_req_o),
        .bank_add_o   (bank_add_o),
        .bank_wen_o   (bank_wen_o),
        .bank_wdata_o (bank_wdata_o),
        .bank_be_o    (bank_be_o),
        .bank_rdata_i (bank_rdata_i)
    );

    always #5 clk = ~clk;

    // Bank SRAM model: word w of bank b initialised to 0xA0000000 + b*0x100 + w.
    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (rst) begin
                for (int w = 0; w < 16; w++) begin
                    mem[b][w] <= 32'hA000_0000 + 32'(b) * 32'h100 + 32'(w);
                end
            end else if (bank_req_o[b]) begin
                if (bank_wen_o[b]) begin
                    rdata_q[b] <= mem[b][bank_add_o[b*BAW +: 4]];
                end else begin
                    for (int i = 0; i < BW; i++) begin
                        if (bank_be_o[b*BW + i]) begin
                            mem[b][bank_add_o[b*BAW +: 4]][i*8 +: 8] <= bank_wdata_o[b*DW + i*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        for (int b = 0; b < NB; b++) begin
            bank_rdata_i[b*DW +: DW] = rdata_q[b];
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic set_req(input int k, input logic [31:0] addr, input logic wen, input logic [31:0] wd);
        add_i[k*AW +: AW]   = addr;
        wen_i[k]            = wen;
        wdata_i[k*DW +: DW] = wd;
        be_i[k*BW +: BW]    = 4'hF;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NR-1:0] pend;
        logic [NR-1:0] exp;
        int g1, g3;

        rst = 1'b1; req_i = '0; add_i = '0; wen_i = '1; wdata_i = '0; be_i = '1;
        for (int k = 0; k < NR; k++) set_req(k, 32'h08, 1'b1, 32'h0);
        req_i = 4'hF;
        repeat (2) begin
            @(posedge clk); #1;
            chk("rst_rvalid", 64'(r_valid_o), 64'h0);
            chk("rst_rdata", 64'(|r_rdata_o), 64'h0);
        end
        @(negedge clk);
        rst = 1'b0;

        // all four load bank 2, each holds until granted
        pend = 4'hF;
        for (int c = 0; c < 4; c++) begin
            req_i = pend; #1;
            exp = 4'b0001 << c;
            chk("conf_gnt", 64'(gnt_o), 64'(exp));
            @(posedge clk); #1;
            chk("conf_rvalid", 64'(r_valid_o), 64'(exp));
            chk("conf_rdata", 64'(r_rdata_o[c*DW +: DW]), 64'hA000_0200);
            pend = pend & ~exp;
            @(negedge clk);
        end

        req_i = '0; #1;
        chk("idle_bank_req", 64'(bank_req_o), 64'h0);
        chk("idle_bank_add", 64'(|bank_add_o), 64'h0);

        // four requesters on four distinct banks
        for (int k = 0; k < NR; k++) set_req(k, 32'(k * 4), 1'b1, 32'h0);
        req_i = 4'hF; #1;
        chk("par_gnt", 64'(gnt_o), 64'hF);
        chk("par_bank_req", 64'(bank_req_o), 64'h0F);
        @(posedge clk); #1;
        chk("par_rvalid", 64'(r_valid_o), 64'hF);
        chk("par_rdata0", 64'(r_rdata_o[0 +: DW]), 64'hA000_0000);
        chk("par_rdata1", 64'(r_rdata_o[32 +: DW]), 64'hA000_0100);
        chk("par_rdata2", 64'(r_rdata_o[64 +: DW]), 64'hA000_0200);
        chk("par_rdata3", 64'(r_rdata_o[96 +: DW]), 64'hA000_0300);
        @(negedge clk);
        req_i = '0;

        // requesters 1 and 3 hammer bank 5
        set_req(1, 32'h14, 1'b1, 32'h0);
        set_req(3, 32'h14, 1'b1, 32'h0);
        req_i = 4'b1010;
        g1 = 0; g3 = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk("fair_gnt", 64'(gnt_o), (c % 2 == 0) ? 64'h2 : 64'h8);
            g1 += int'(gnt_o[1]);
            g3 += int'(gnt_o[3]);
            @(negedge clk);
        end
        chk("fair_cnt1", 64'(g1), 64'd4);
        chk("fair_cnt3", 64'(g3), 64'd4);
        req_i = '0;

        // store then load at 0x20 -> bank 0, word 1
        set_req(0, 32'h20, 1'b0, 32'hCAFE_BABE);
        req_i = 4'b0001; #1;
        chk("wr_gnt", 64'(gnt_o), 64'h1);
        chk("wr_bank_req", 64'(bank_req_o), 64'h01);
        chk("wr_bank_add", 64'(bank_add_o[0 +: BAW]), 64'h1);
        chk("wr_bank_wen", 64'(bank_wen_o[0]), 64'h0);
        chk("wr_bank_wdata", 64'(bank_wdata_o[0 +: DW]), 64'hCAFE_BABE);
        @(posedge clk); #1;
        chk("wr_rvalid", 64'(r_valid_o), 64'h1);
        chk("wr_rdata", 64'(r_rdata_o[0 +: DW]), 64'h0);
        @(negedge clk);
        wen_i[0] = 1'b1; #1;
        chk("rd_gnt", 64'(gnt_o), 64'h1);
        @(posedge clk); #1;
        chk("rd_rvalid", 64'(r_valid_o), 64'h1);
        chk("rd_rdata", 64'(r_rdata_o[0 +: DW]), 64'hCAFE_BABE);
        @(negedge clk);
        req_i = '0;

        // reset the cycle after a load grant; bank 2 pointer would otherwise sit at 2
        set_req(1, 32'h08, 1'b1, 32'h0);
        req_i = 4'b0010; #1;
        chk("mid_gnt", 64'(gnt_o), 64'h2);
        @(negedge clk);
        req_i = '0;
        rst = 1'b1; #1;
        chk("mid_rvalid_rst", 64'(r_valid_o), 64'h0);
        @(posedge clk); #1;
        chk("mid_rvalid_post", 64'(r_valid_o), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < NR; k++) set_req(k, 32'h08, 1'b1, 32'h0);
        req_i = 4'hF; #1;
        chk("mid_ptr_gnt", 64'(gnt_o), 64'h1);
        @(posedge clk); #1;
        chk("mid_rvalid_new", 64'(r_valid_o), 64'h1);
        chk("mid_rdata_new", 64'(r_rdata_o[0 +: DW]), 64'hA000_0200);
        @(negedge clk);
        req_i = '0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/hwce_wmem_arbiter.md
Name: hwce_wmem_arbiter

Overview:
Shares the HWCE weight-memory banks between several TCDM-style requesters (DMA ports and engine weight-fetch ports).
- Decodes the bank from the word-interleaved address.
- Arbitrates each bank round-robin, granting in the request cycle.
- Routes the single-cycle SRAM read response back to the granted requester one cycle later.
- Sits between requester ports and the weight-memory bank array. Replaces the fixed point-to-point mapping with real contention handling and real read data.

Parameters:
N_REQ, 4, number of requester ports (>=2)
N_BANKS, 8, number of weight-memory banks (power of 2, >=2)
ADDR_WIDTH, 32, requester address width
DATA_WIDTH, 32, data width
BE_WIDTH, DATA_WIDTH/8, byte-enable width
LSB_ADDR, 2, lowest address bit used for bank select (word interleave)
BANK_ADDR_WIDTH, 12, word address width inside a bank

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
req_i  in  N_REQ  request, held until granted
add_i  in  N_REQ*ADDR_WIDTH  byte address, stable while req_i high
wen_i  in  N_REQ  0=store, 1=load
wdata_i  in  N_REQ*DATA_WIDTH  write data
be_i  in  N_REQ*BE_WIDTH  byte enables
gnt_o  out  N_REQ  grant, combinational, same cycle as req
r_valid_o  out  N_REQ  response valid, one cycle after gnt (loads and stores)
r_rdata_o  out  N_REQ*DATA_WIDTH  load data, valid with r_valid_o
bank_req_o  out  N_BANKS  bank chip select
bank_add_o  out  N_BANKS*BANK_ADDR_WIDTH  word address in bank
bank_wen_o  out  N_BANKS  0=write, 1=read
bank_wdata_o  out  N_BANKS*DATA_WIDTH  write data
bank_be_o  out  N_BANKS*BE_WIDTH  byte enables
bank_rdata_i  in  N_BANKS*DATA_WIDTH  read data, one cycle after bank_req_o

Behaviour:
- Interface timing: one clock; reset is synchronous and active-high.
- Bank decode: bank = add_i[LSB_ADDR +: log2(N_BANKS)]. Word address = add_i[LSB_ADDR+log2(N_BANKS) +: BANK_ADDR_WIDTH]. Higher bits are ignored.
- Per-bank arbitration: one round-robin arbiter per bank, pointer rr_q[b] (log2(N_REQ) bits).
  - Winner is the first requester targeting bank b, scanning from rr_q[b] upward with wrap.
  - On grant to k: rr_q[b] <= (k+1) mod N_REQ.
  - If no grant on that bank, rr_q[b] holds.
- Grant: gnt_o[k]=1 iff requester k wins its bank. Bank outputs carry the winner's fields. bank_req_o[b]=0 with no winner; other bank outputs are don't-care then, driven 0.
- Independence: requesters targeting different banks are all granted in the same cycle.
- Response tracking per requester, registered on gnt:
  - valid_q[k] <= gnt_o[k]
  - bank_q[k] <= bank
  - rd_q[k] <= wen_i[k]
- Response outputs:
  - r_valid_o[k] = valid_q[k].
  - r_rdata_o[k] = bank_rdata_i[bank_q[k]] when valid_q[k] & rd_q[k], else 0.
- Latency: load data one cycle after gnt. Back-to-back grants to the same requester give a response every cycle.
- Fairness: with all N_REQ hammering one bank, each is granted exactly once per N_REQ cycles.
- Reset values: rr_q=0, valid_q=0, bank_q=0, rd_q=0. Outputs at reset: r_valid_o=0, r_rdata_o=0. gnt_o and bank_* follow inputs combinationally.
- Reset mid-operation: a response pending from the cycle before rst is dropped (r_valid_o=0 in the cycle after reset asserts). Requesters reissue.
- Protocol: a requester dropping req_i before gnt is legal; the request is lost and no response is issued. Changing add_i while waiting is a protocol violation; no ordering is guaranteed.
- No combinational path from bank_rdata_i to gnt_o.

Decomposition:
- Package hwce_wmem_pkg:
  - BANK_SEL_W = $clog2(N_BANKS), REQ_IDX_W = $clog2(N_REQ)
  - Typedef for bank index
  - Function for bank/word-address decode
- Sub-module hwce_rr_arb (N inputs, round-robin pointer, one-hot grant, pointer update on grant), instantiated once per bank.

Test Plan:
- Reset: hold rst 2 cycles with req_i=4'b1111 -> r_valid_o=0 in the cycle after each reset cycle. After release, rr_q=0, so requester 0 is granted first on a shared bank.
- Parallel banks: req 0..3 to addr 0x00,0x04,0x08,0x0C, loads -> all gnt same cycle; bank_req_o=8'h0F. Next cycle r_valid_o=4'hF, each with its bank's rdata.
- Conflict: all 4 requesters load bank 2 (addr 0x08) and hold until granted -> grants in order 0,1,2,3 over 4 consecutive cycles; each r_valid one cycle after its gnt.
- Fairness: requesters 1 and 3 continuously hit bank 5 for 8 cycles -> grants alternate 1,3,1,3; 4 grants each.
- Write then read: requester 0 stores 0xCAFEBABE, be=4'hF, to 0x20, then loads 0x20 -> bank 0, word addr 1. Store r_valid has rdata=0; load returns 0xCAFEBABE.
- Reset mid-operation: assert rst the cycle after a load gnt -> no r_valid_o for that load; rr pointers return to 0.
